// File: rtl/multichannel_peak_detector.sv
// Multi-channel burst peak detector: captures per-channel peak amplitude and timestamp within
// one event frame and hands the frame to the localisation logic over a valid/ack handshake.
module multichannel_peak_detector #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned TW        = 32,
    parameter int unsigned QUIET_LEN = 50,
    parameter int unsigned WINDOW    = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] data,
    input  logic              data_valid,
    input  logic [DW-1:0]     high,
    input  logic [DW-1:0]     low,
    input  logic              ack,
    output logic              valid,
    output logic [NCH*TW-1:0] detect_time,
    output logic [NCH*DW-1:0] peak,
    output logic [NCH-1:0]    hit_mask,
    output logic              overrun
);

    localparam int unsigned QW = $clog2(QUIET_LEN + 1);
    localparam int unsigned WW = $clog2(WINDOW + 1);
    localparam logic [QW-1:0] QuietLast = QW'(QUIET_LEN);
    localparam logic [WW-1:0] WinFull   = WW'(WINDOW);

    typedef enum logic [1:0] {ChIdle, ChActive, ChDone} ch_state_e;
    typedef enum logic [1:0] {FrIdle, FrCapture, FrReport} fr_state_e;

    ch_state_e       ch_q    [NCH];
    ch_state_e       ch_d    [NCH];
    logic [DW-1:0]   pmax_q  [NCH];
    logic [DW-1:0]   pmax_d  [NCH];
    logic [TW-1:0]   tmax_q  [NCH];
    logic [TW-1:0]   tmax_d  [NCH];
    logic [QW-1:0]   quiet_q [NCH];
    logic [QW-1:0]   quiet_d [NCH];
    logic [NCH-1:0]  hit_q, hit_d;

    logic [NCH-1:0]  sig, idle_q, trig, active_d, done_d;
    fr_state_e       fr_q;
    logic [TW-1:0]   ts_q;
    logic [WW-1:0]   win_q, win_d;
    logic            armed, frame_release, ov_set, report_go;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            sig[k]    = data_valid &&
                        (data[k*DW +: DW] > high || data[k*DW +: DW] < low);
            idle_q[k] = (ch_q[k] == ChIdle);
        end
    end

    // Arming uses the pre-increment window count, so a trigger on the expiring sample is kept.
    assign armed         = (fr_q == FrIdle) || (fr_q == FrCapture && win_q != WinFull);
    assign trig          = sig & idle_q & {NCH{armed}};
    assign frame_release = (fr_q == FrReport) && ack;
    assign win_d         = (win_q == WinFull) ? win_q : win_q + WW'(1);

    always_comb begin
        ov_set = 1'b0;
        if (fr_q == FrReport) begin
            ov_set = |sig;
        end else if (fr_q == FrCapture && !armed) begin
            ov_set = |(sig & idle_q);
        end
    end

    // Per-channel next state; the frame FSM looks at it so valid rises on the deciding sample.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            ch_d[k]    = ch_q[k];
            pmax_d[k]  = pmax_q[k];
            tmax_d[k]  = tmax_q[k];
            quiet_d[k] = quiet_q[k];
            hit_d[k]   = hit_q[k];
            if (data_valid) begin
                unique case (ch_q[k])
                    ChIdle: begin
                        if (trig[k]) begin
                            ch_d[k]    = ChActive;
                            pmax_d[k]  = data[k*DW +: DW];
                            tmax_d[k]  = ts_q;
                            quiet_d[k] = '0;
                            hit_d[k]   = 1'b1;
                        end
                    end
                    ChActive: begin
                        if (sig[k]) begin
                            quiet_d[k] = '0;
                            if (data[k*DW +: DW] > pmax_q[k]) begin
                                pmax_d[k] = data[k*DW +: DW];
                                tmax_d[k] = ts_q;
                            end
                        end else begin
                            quiet_d[k] = quiet_q[k] + QW'(1);
                            if (quiet_d[k] == QuietLast) begin
                                ch_d[k] = ChDone;
                            end
                        end
                    end
                    ChDone: ;
                    default: ch_d[k] = ChIdle;
                endcase
            end
            active_d[k] = (ch_d[k] == ChActive);
            done_d[k]   = (ch_d[k] == ChDone);
        end
    end

    assign report_go = data_valid && (fr_q == FrCapture) && !(|active_d) &&
                       ((&done_d) || (win_d == WinFull));

    always_ff @(posedge clk) begin
        if (rst || frame_release) begin
            for (int k = 0; k < NCH; k++) begin
                ch_q[k]    <= ChIdle;
                pmax_q[k]  <= '0;
                tmax_q[k]  <= '0;
                quiet_q[k] <= '0;
            end
            hit_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                ch_q[k]    <= ch_d[k];
                pmax_q[k]  <= pmax_d[k];
                tmax_q[k]  <= tmax_d[k];
                quiet_q[k] <= quiet_d[k];
            end
            hit_q <= hit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q    <= '0;
            overrun <= 1'b0;
        end else begin
            if (data_valid) begin
                ts_q <= ts_q + TW'(1);
            end
            if (ov_set) begin
                overrun <= 1'b1;
            end else if (frame_release) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fr_q        <= FrIdle;
            win_q       <= '0;
            valid       <= 1'b0;
            detect_time <= '0;
            peak        <= '0;
            hit_mask    <= '0;
        end else begin
            unique case (fr_q)
                FrIdle: begin
                    if (|trig) begin
                        fr_q  <= FrCapture;
                        win_q <= '0;
                    end
                end
                FrCapture: begin
                    if (data_valid) begin
                        win_q <= win_d;
                    end
                    if (report_go) begin
                        fr_q     <= FrReport;
                        valid    <= 1'b1;
                        hit_mask <= hit_d;
                        for (int k = 0; k < NCH; k++) begin
                            detect_time[k*TW +: TW] <= hit_d[k] ? tmax_d[k] : '0;
                            peak[k*DW +: DW]        <= hit_d[k] ? pmax_d[k] : '0;
                        end
                    end
                end
                FrReport: begin
                    if (ack) begin
                        fr_q  <= FrIdle;
                        valid <= 1'b0;
                    end
                end
                default: fr_q <= FrIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_multichannel_peak_detector.sv
// Bench for multichannel_peak_detector: directed scenarios plus randomized traffic, every cycle
// compared against a sample-level behavioural model of the frame rules.
module tb_multichannel_peak_detector;

    localparam int unsigned NCH       = 4;
    localparam int unsigned DW        = 16;
    localparam int unsigned TW        = 8;
    localparam int unsigned QUIET_LEN = 5;
    localparam int unsigned WINDOW    = 24;
    localparam int unsigned TSMOD     = 1 << TW;

    logic              clk = 1'b0;
    logic              rst, data_valid, ack;
    logic [NCH*DW-1:0] data;
    logic [DW-1:0]     high, low;
    logic              valid, overrun;
    logic [NCH*TW-1:0] detect_time;
    logic [NCH*DW-1:0] peak;
    logic [NCH-1:0]    hit_mask;

    int unsigned smp [NCH];
    int unsigned burst_left [NCH];
    int unsigned calm;
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state: a frame is "capturing" or "pending" (reported, awaiting ack).
    int unsigned       m_ts, m_since;
    bit                m_pending, m_capturing;
    bit                m_burst [NCH];
    bit                m_finished [NCH];
    bit                m_hit [NCH];
    int unsigned       m_quiet [NCH];
    int unsigned       m_best [NCH];
    int unsigned       m_best_t [NCH];
    logic              m_valid, m_overrun;
    logic [NCH*TW-1:0] m_time;
    logic [NCH*DW-1:0] m_peak;
    logic [NCH-1:0]    m_mask;

    always #5 clk = ~clk;

    multichannel_peak_detector #(
        .NCH(NCH), .DW(DW), .TW(TW), .QUIET_LEN(QUIET_LEN), .WINDOW(WINDOW)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .high(high), .low(low),
        .ack(ack), .valid(valid), .detect_time(detect_time), .peak(peak),
        .hit_mask(hit_mask), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear_channels();
        for (int k = 0; k < NCH; k++) begin
            m_burst[k] = 0; m_finished[k] = 0; m_hit[k] = 0;
            m_quiet[k] = 0; m_best[k] = 0; m_best_t[k] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear_channels();
        m_ts = 0; m_since = 0; m_pending = 0; m_capturing = 0;
        m_valid = 0; m_overrun = 0; m_time = '0; m_peak = '0; m_mask = '0;
    endtask

    // Applies the rules to one clock with the inputs currently driven.
    task automatic model_step();
        bit          sg [NCH];
        bit          ov_set, armed, any_new, none_burst, all_fin;
        int unsigned hi, lo;
        if (rst) begin
            model_reset();
            return;
        end
        hi = int'(high);
        lo = int'(low);
        ov_set = 0;
        for (int k = 0; k < NCH; k++) begin
            sg[k] = data_valid && (smp[k] > hi || smp[k] < lo);
            if (sg[k] && (m_pending || (m_capturing && !m_burst[k] && !m_finished[k] &&
                                        m_since >= WINDOW)))
                ov_set = 1;
        end
        if (m_pending) begin
            if (ack) begin
                m_pending = 0;
                m_valid = 0;
                model_clear_channels();
                m_overrun = ov_set;
            end else if (ov_set) begin
                m_overrun = 1;
            end
        end else begin
            if (ov_set) m_overrun = 1;
            if (data_valid) begin
                armed = !m_capturing || m_since < WINDOW;
                any_new = 0;
                for (int k = 0; k < NCH; k++) begin
                    if (!m_burst[k] && !m_finished[k]) begin
                        if (sg[k] && armed) begin
                            m_burst[k] = 1; m_hit[k] = 1; m_quiet[k] = 0;
                            m_best[k] = smp[k]; m_best_t[k] = m_ts;
                            any_new = 1;
                        end
                    end else if (m_burst[k]) begin
                        if (sg[k]) begin
                            m_quiet[k] = 0;
                            if (smp[k] > m_best[k]) begin
                                m_best[k] = smp[k]; m_best_t[k] = m_ts;
                            end
                        end else begin
                            m_quiet[k]++;
                            if (m_quiet[k] == QUIET_LEN) begin
                                m_burst[k] = 0; m_finished[k] = 1;
                            end
                        end
                    end
                end
                if (m_capturing) begin
                    m_since++;
                    none_burst = 1; all_fin = 1;
                    for (int k = 0; k < NCH; k++) begin
                        if (m_burst[k]) none_burst = 0;
                        if (!m_finished[k]) all_fin = 0;
                    end
                    if (none_burst && (all_fin || m_since >= WINDOW)) begin
                        m_capturing = 0; m_pending = 1; m_valid = 1;
                        for (int k = 0; k < NCH; k++) begin
                            m_mask[k] = m_hit[k];
                            m_time[k*TW +: TW] = m_hit[k] ? TW'(m_best_t[k]) : '0;
                            m_peak[k*DW +: DW] = m_hit[k] ? DW'(m_best[k]) : '0;
                        end
                    end
                end else if (any_new) begin
                    m_capturing = 1;
                    m_since = 0;
                end
            end
        end
        if (data_valid) m_ts = (m_ts + 1) % TSMOD;
    endtask

    task automatic cycle();
        for (int k = 0; k < NCH; k++) data[k*DW +: DW] = DW'(smp[k]);
        model_step();
        @(posedge clk);
        #1;
        check("valid", 128'(valid), 128'(m_valid));
        check("overrun", 128'(overrun), 128'(m_overrun));
        check("hit_mask", 128'(hit_mask), 128'(m_mask));
        check("detect_time", 128'(detect_time), 128'(m_time));
        check("peak", 128'(peak), 128'(m_peak));
    endtask

    task automatic step4(input int unsigned s0, input int unsigned s1,
                         input int unsigned s2, input int unsigned s3);
        data_valid = 1'b1;
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        cycle();
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!valid && n < limit) begin
            step4(calm, calm, calm, calm);
            n++;
        end
        check("wait_valid", 128'(valid), 128'(1));
    endtask

    task automatic release_frame();
        ack = 1'b1;
        step4(calm, calm, calm, calm);
        ack = 1'b0;
        check("release", 128'(valid), 128'(0));
    endtask

    int unsigned       t0;
    int unsigned       offs [NCH];
    int unsigned       pks [NCH];
    logic [NCH*TW-1:0] sv_time;
    logic [NCH*DW-1:0] sv_peak;
    logic [NCH-1:0]    sv_mask;

    initial begin
        model_reset();
        rst = 1'b1; ack = 1'b0; high = 16'd150; low = 16'd0; calm = 100;
        step4(calm, calm, calm, calm);
        step4(calm, calm, calm, calm);
        rst = 1'b0;
        check("rst_valid", 128'(valid), 128'(0));
        check("rst_mask", 128'(hit_mask), 128'(0));
        check("rst_overrun", 128'(overrun), 128'(0));

        // Single burst on ch0; 100 is in band, so the burst starts at ts=11.
        for (int i = 0; i < 10; i++) step4(calm, calm, calm, calm);
        step4(100, calm, calm, calm);
        step4(300, calm, calm, calm);
        step4(200, calm, calm, calm);
        wait_valid(100);
        check("s1_mask", 128'(hit_mask), 128'(4'b0001));
        check("s1_peak0", 128'(peak[15:0]), 128'(300));
        check("s1_time0", 128'(detect_time[7:0]), 128'(11));
        check("s1_peak_rest", 128'(peak[63:16]), 128'(0));
        release_frame();

        // TDOA: all channels finish before the window.
        high = 16'd1000; low = 16'd0; calm = 500;
        offs = '{0, 3, 7, 1};
        pks = '{2000, 2300, 2100, 2200};
        t0 = m_ts;
        for (int i = 0; i <= 13; i++) begin
            for (int k = 0; k < NCH; k++)
                smp[k] = (i == int'(offs[k])) ? pks[k] : (i == int'(offs[k]) + 1) ? 1500 : calm;
            data_valid = 1'b1;
            cycle();
            if (i == 12) check("tdoa_early", 128'(valid), 128'(0));
            if (i == 13) check("tdoa_valid", 128'(valid), 128'(1));
        end
        check("tdoa_mask", 128'(hit_mask), 128'(4'b1111));
        for (int k = 0; k < NCH; k++) begin
            check("tdoa_time", 128'(detect_time[k*TW +: TW]), 128'((t0 + offs[k]) % TSMOD));
            check("tdoa_peak", 128'(peak[k*DW +: DW]), 128'(pks[k]));
        end
        release_frame();

        // Low-side trigger with a tie: the first 5 wins.
        low = 16'd10;
        t0 = m_ts;
        step4(calm, 5, calm, calm);
        step4(calm, 3, calm, calm);
        step4(calm, 5, calm, calm);
        step4(calm, 3, calm, calm);
        wait_valid(60);
        check("tie_mask", 128'(hit_mask), 128'(4'b0010));
        check("tie_peak1", 128'(peak[31:16]), 128'(5));
        check("tie_time1", 128'(detect_time[15:8]), 128'(t0 % TSMOD));
        release_frame();

        // Window expiry: ch2 arrives one sample after the window closed.
        low = 16'd0;
        for (int i = 0; i <= 26; i++) step4(1100, calm, (i == 25) ? 1500 : calm, calm);
        wait_valid(60);
        check("win_mask", 128'(hit_mask), 128'(4'b0001));
        check("win_overrun", 128'(overrun), 128'(1));
        check("win_peak2", 128'(peak[47:32]), 128'(0));

        // Backpressure: frame held while channels keep triggering.
        sv_time = detect_time; sv_peak = peak; sv_mask = hit_mask;
        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < NCH; k++)
                smp[k] = ($urandom_range(0, 9) == 0) ? 1100 + $urandom_range(0, 50) : calm;
            data_valid = 1'b1;
            cycle();
        end
        check("bp_time", 128'(detect_time), 128'(sv_time));
        check("bp_peak", 128'(peak), 128'(sv_peak));
        check("bp_mask", 128'(hit_mask), 128'(sv_mask));
        check("bp_overrun", 128'(overrun), 128'(1));
        release_frame();
        check("bp_ov_clear", 128'(overrun), 128'(0));
        step4(calm, calm, calm, 1234);
        wait_valid(60);
        check("bp_new_mask", 128'(hit_mask), 128'(4'b1000));
        check("bp_new_peak3", 128'(peak[63:48]), 128'(1234));
        release_frame();

        // Reset mid-capture, then a burst spanning the timestamp wrap.
        step4(calm, calm, calm, 1111);
        for (int i = 0; i < 3; i++) step4(calm, calm, calm, calm);
        rst = 1'b1;
        step4(calm, calm, calm, calm);
        rst = 1'b0;
        check("mid_rst_valid", 128'(valid), 128'(0));
        check("mid_rst_peak", 128'(peak), 128'(0));
        check("mid_rst_time", 128'(detect_time), 128'(0));
        for (int i = 0; i < 254; i++) step4(calm, calm, calm, calm);
        step4(1100, calm, calm, calm);
        step4(1200, calm, calm, calm);
        step4(1300, calm, calm, calm);
        step4(1250, calm, calm, calm);
        wait_valid(60);
        check("wrap_time0", 128'(detect_time[7:0]), 128'(0));
        check("wrap_peak0", 128'(peak[15:0]), 128'(1300));
        check("wrap_mask", 128'(hit_mask), 128'(4'b0001));
        release_frame();

        // Randomized traffic.
        for (int k = 0; k < NCH; k++) burst_left[k] = 0;
        for (int n = 0; n < 5000; n++) begin
            if (n % 800 == 0) begin
                high = DW'($urandom_range(300, 60000));
                low = DW'($urandom_range(0, int'(high)));
            end
            data_valid = ($urandom_range(0, 3) != 0);
            ack = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 599) == 0);
            for (int k = 0; k < NCH; k++) begin
                if (burst_left[k] > 0 && $urandom_range(0, 4) != 0) begin
                    if ($urandom_range(0, 1) == 1 && low > 0)
                        smp[k] = $urandom_range(int'(low) - 1, (low > 4) ? int'(low) - 4 : 0);
                    else
                        smp[k] = int'(high) + 1 + $urandom_range(0, 3);
                end else begin
                    smp[k] = $urandom_range(int'(low), int'(high));
                end
                if (burst_left[k] > 0) begin
                    if (data_valid) burst_left[k]--;
                end else if ($urandom_range(0, 149) == 0) begin
                    burst_left[k] = $urandom_range(1, 10);
                end
            end
            cycle();
        end
        rst = 1'b0;
        ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
